// File: rtl/bus_ready_controller.sv
// ---------------------------------------------------------------------------
// bus_ready_controller
//
// Generates the CPU bus handshake (cpu_mem_ready) for the memory-mapped
// targets behind the CPU: RAM, VDP, status registers, DSP and the flash
// reader.
// - RAM, VDP, status and DSP have a fixed access latency set by a per-target
//   parameter and counted down in a 4-bit wait counter.
// - Flash reads wait for the flash reader's flash_read_ready pulse.
//   An 8-bit counter bounds that wait. When the bound expires, the
//   transfer is completed anyway and the sticky bus_timeout flag is set.
//
// Ports
//   clk               system clock, rising-edge active
//   reset             asynchronous, active-high reset
//   cpu_mem_valid     CPU request pending
//   cpu_ram_en        decoded select: CPU RAM
//   vdp_en            decoded select: VDP
//   status_en         decoded select: status registers
//   dsp_en            decoded select: DSP
//   flash_read_en     decoded select: flash reader
//   flash_read_ready  one-cycle pulse from the flash reader, read data valid
//   timeout_clear     clears bus_timeout
//   cpu_mem_ready     registered one-cycle transfer-complete pulse
//   bus_busy          registered, high while a transfer is in flight
//   bus_timeout       registered sticky flash-timeout flag
//
// Timing
//   - cpu_mem_ready is high during the last busy cycle of WAIT or FLASH.
//   - DONE follows as one quiet cycle, with both ready and busy low.
//   - After DONE the FSM returns to IDLE. A cpu_mem_valid that the CPU has
//     not yet dropped is therefore never taken as a second request.
//   - For a wait target with latency N, the FSM spends N+1 cycles in WAIT.
//     The ready pulse falls in the last of those cycles.
//
// State | meaning
// IDLE  | waiting for cpu_mem_valid with a decoded select
// WAIT  | fixed-latency access, wait_cnt counting down to 0
// FLASH | waiting for flash_read_ready, tmo_cnt counting up
// DONE  | one-cycle gap after completion, then back to IDLE
// ---------------------------------------------------------------------------
module bus_ready_controller #(
  parameter int RAM_WAIT      = 0,
  parameter int VDP_WAIT      = 1,
  parameter int STATUS_WAIT   = 0,
  parameter int DSP_WAIT      = 1,
  parameter int FLASH_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic cpu_mem_valid,
  input  logic cpu_ram_en,
  input  logic vdp_en,
  input  logic status_en,
  input  logic dsp_en,
  input  logic flash_read_en,
  input  logic flash_read_ready,
  input  logic timeout_clear,
  output logic cpu_mem_ready,
  output logic bus_busy,
  output logic bus_timeout
);

  localparam logic [3:0] RAM_W    = 4'(RAM_WAIT);
  localparam logic [3:0] VDP_W    = 4'(VDP_WAIT);
  localparam logic [3:0] STATUS_W = 4'(STATUS_WAIT);
  localparam logic [3:0] DSP_W    = 4'(DSP_WAIT);
  localparam logic [7:0] TMO_MAX  = 8'(FLASH_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FLASH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state;
  logic [3:0] wait_cnt;
  logic [7:0] tmo_cnt;

  logic       wait_sel;
  logic [3:0] wait_load;
  logic       tmo_set;

  // Fixed-latency target selection.
  // The if-chain gives the priority ram > vdp > status > dsp.
  // Flash is taken only when none of these four is selected.
  always_comb begin
    wait_sel  = cpu_ram_en | vdp_en | status_en | dsp_en;
    wait_load = 4'd0;
    if (cpu_ram_en)     wait_load = RAM_W;
    else if (vdp_en)    wait_load = VDP_W;
    else if (status_en) wait_load = STATUS_W;
    else if (dsp_en)    wait_load = DSP_W;
  end

  // Timeout fires only while still waiting on a live request.
  // flash_read_ready in the same cycle wins, so bus_timeout is left alone.
  assign tmo_set = (state == FLASH) && !cpu_mem_ready && cpu_mem_valid &&
                   !flash_read_ready && (tmo_cnt == TMO_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      wait_cnt      <= 4'd0;
      tmo_cnt       <= 8'd0;
      cpu_mem_ready <= 1'b0;
      bus_busy      <= 1'b0;
      bus_timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cpu_mem_ready <= 1'b0;
          bus_busy      <= 1'b0;
          if (cpu_mem_valid && wait_sel) begin
            state         <= WAIT;
            wait_cnt      <= wait_load;
            // Zero-latency targets complete in the very first WAIT cycle.
            cpu_mem_ready <= (wait_load == 4'd0);
            bus_busy      <= 1'b1;
          end else if (cpu_mem_valid && flash_read_en) begin
            state    <= FLASH;
            tmo_cnt  <= 8'd0;
            bus_busy <= 1'b1;
          end
        end

        WAIT: begin
          if (cpu_mem_ready) begin
            // The ready pulse has been presented; the transfer is finished.
            state         <= DONE;
            cpu_mem_ready <= 1'b0;
            bus_busy      <= 1'b0;
          end else if (!cpu_mem_valid) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            bus_busy <= 1'b0;
          end else begin
            wait_cnt      <= wait_cnt - 4'd1;
            cpu_mem_ready <= (wait_cnt == 4'd1);
          end
        end

        FLASH: begin
          if (cpu_mem_ready) begin
            state         <= DONE;
            cpu_mem_ready <= 1'b0;
            bus_busy      <= 1'b0;
            tmo_cnt       <= 8'd0;
          end else if (!cpu_mem_valid) begin
            state    <= IDLE;
            tmo_cnt  <= 8'd0;
            bus_busy <= 1'b0;
          end else if (flash_read_ready) begin
            cpu_mem_ready <= 1'b1;
          end else if (tmo_cnt == TMO_MAX) begin
            cpu_mem_ready <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        DONE: begin
          state         <= IDLE;
          cpu_mem_ready <= 1'b0;
          bus_busy      <= 1'b0;
        end
      endcase

      // Set has priority over clear.
      if (tmo_set)
        bus_timeout <= 1'b1;
      else if (timeout_clear)
        bus_timeout <= 1'b0;
    end
  end

endmodule

// File: doc/bus_ready_controller.md
BUS_READY_CONTROLLER -- requirements
Module: bus_ready_controller

Interface
REQ-001 Parameter RAM_WAIT, default 0: wait cycles before cpu_mem_ready for CPU RAM accesses (0..15).
REQ-002 Parameter VDP_WAIT, default 1: wait cycles for VDP accesses (0..15).
REQ-003 Parameter STATUS_WAIT, default 0: wait cycles for status accesses (0..15).
REQ-004 Parameter DSP_WAIT, default 1: wait cycles for DSP accesses (0..15).
REQ-005 Parameter FLASH_TIMEOUT, default 255: maximum cycles spent waiting for flash_read_ready (1..255).
REQ-006 clk  input  1  single system clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 cpu_mem_valid  input  1  CPU bus request pending.
REQ-009 cpu_ram_en, vdp_en, status_en, dsp_en, flash_read_en  input  1 each  decoded target selects.
REQ-010 flash_read_ready  input  1  one-cycle pulse from the flash reader: read data valid.
REQ-011 timeout_clear  input  1  clears the bus_timeout flag.
REQ-012 cpu_mem_ready  output  1  registered; one-cycle transfer-complete pulse to the CPU.
REQ-013 bus_busy  output  1  registered; high while a transfer is accepted and not yet completed.
REQ-014 bus_timeout  output  1  registered; sticky flash-timeout flag.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, WAIT, FLASH, DONE.
REQ-016 In IDLE with cpu_mem_valid=1 and at least one select high, the FSM SHALL accept the request.
REQ-017 When several selects are high together, priority SHALL be ram > vdp > status > dsp > flash.
REQ-018 In IDLE with cpu_mem_valid=1 and no select high, the FSM SHALL stay in IDLE with cpu_mem_ready=0.
REQ-019 On acceptance of a RAM, VDP, status or DSP request, the block SHALL load a 4-bit counter with that target's WAIT parameter and enter WAIT.
REQ-020 In WAIT the counter SHALL decrement each cycle; when it is 0, the next edge SHALL drive cpu_mem_ready=1 and enter DONE.
REQ-021 Latency: if the acceptance edge is cycle 0, cpu_mem_ready SHALL be high during cycle N+1, where N is the target's WAIT value.
REQ-022 On acceptance of a flash request, the block SHALL clear an 8-bit timeout counter and enter FLASH.
REQ-023 In FLASH, flash_read_ready=1 SHALL cause cpu_mem_ready=1 on the next cycle and a transition to DONE.
REQ-024 In FLASH, when the timeout counter equals FLASH_TIMEOUT without flash_read_ready, the block SHALL assert cpu_mem_ready=1 on the next cycle, set bus_timeout=1 and enter DONE.
REQ-025 If flash_read_ready and the timeout condition occur in the same cycle, flash_read_ready SHALL win and bus_timeout SHALL stay unchanged.
REQ-026 cpu_mem_ready SHALL be high for exactly one cycle per accepted request and never high in any other state.
REQ-027 DONE SHALL last exactly one cycle with cpu_mem_ready=0, then return to IDLE; this guarantees a one-cycle gap, so a stale cpu_mem_valid is never re-accepted.
REQ-028 If cpu_mem_valid falls while in WAIT or FLASH, the FSM SHALL return to IDLE on the next edge without asserting cpu_mem_ready or setting bus_timeout.
REQ-029 bus_busy SHALL be 1 in WAIT and FLASH and 0 in IDLE and DONE.
REQ-030 timeout_clear=1 SHALL clear bus_timeout on the next edge; a simultaneous timeout set SHALL take priority over the clear.
REQ-031 The select inputs SHALL be sampled only in IDLE; changes in any other state SHALL be ignored.

Reset
REQ-032 Asserting reset SHALL immediately force the state to IDLE, cpu_mem_ready=0, bus_busy=0, bus_timeout=0 and both counters to 0, including when reset arrives mid-transfer.
REQ-033 After reset is released, the first edge with cpu_mem_valid=1 and a select high SHALL be accepted normally.

Verification
REQ-034 RAM access with RAM_WAIT=0 (valid and cpu_ram_en high at edge 0) -> cpu_mem_ready high in cycle 1 only, bus_busy high in cycle 1 only, DONE in cycle 2, IDLE in cycle 3.
REQ-035 VDP access with VDP_WAIT=3 -> cpu_mem_ready high in cycle 4 only, bus_busy high in cycles 1-4.
REQ-036 Flash read with flash_read_ready pulsed in cycle 6 -> cpu_mem_ready high in cycle 7, bus_timeout stays 0.
REQ-037 Flash read with FLASH_TIMEOUT=8 and no flash_read_ready -> cpu_mem_ready high one cycle after the counter reaches 8 and bus_timeout=1; a following timeout_clear pulse -> bus_timeout=0 on the next edge.
REQ-038 DSP access with DSP_WAIT=5 and cpu_mem_valid dropped in cycle 2 -> no cpu_mem_ready, IDLE in cycle 3; reset asserted mid-WAIT in a repeat run -> all outputs 0 immediately.
REQ-039 cpu_ram_en and flash_read_en both high at acceptance -> RAM timing is used (ready in cycle RAM_WAIT+1); valid held high with no select -> no ready for 20 cycles.
